joypad_irq_ctrl: RTL and testbench

- Sequences joypad interrupt generation and STOP-mode wake-up from the P10–P13 input lines.
- Synchronises the lines, detects a high-to-low transition on the AND of all four lines, debounces it, and raises a level interrupt request that is held until acknowledged.
- Sits beside joypad_io: it consumes the same p1x_c pad inputs and feeds the interrupt controller and the STOP/clock-gating logic.

---
 rtl/joypad_irq_if.sv | 27 ++
 rtl/joypad_irq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_joypad_irq_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/joypad_irq_if.sv
// joypad_irq_if -- signal bundle between the joypad interrupt sequencer and
// its environment (pad inputs, STOP status, interrupt controller handshake).
//   p1x_c     : pad inputs {p13,p12,p11,p10}, active low
//   stop_mode : CPU is in STOP, enables wake generation
//   int_ack   : one-cycle clear of the joypad request
//   int_jp    : level interrupt request
//   wake      : one-cycle STOP exit request
//   busy      : sequencer is debouncing or holding
// master drives the inputs (environment / bench), slave is the controller.
interface joypad_irq_if;
  logic [3:0] p1x_c;
  logic       stop_mode;
  logic       int_ack;
  logic       int_jp;
  logic       wake;
  logic       busy;

  modport master (
    output p1x_c, stop_mode, int_ack,
    input  int_jp, wake, busy
  );

  modport slave (
    input  p1x_c, stop_mode, int_ack,
    output int_jp, wake, busy
  );
endinterface

// File: rtl/joypad_irq_ctrl.sv
// joypad_irq_ctrl -- joypad interrupt and STOP wake-up sequencer.
// Synchronises the four P1x pad lines, detects a falling edge on their AND,
// debounces it for DEBOUNCE_CYC edges, then raises a level interrupt that
// stays set until acknowledged. A release period of DEBOUNCE_CYC all-high
// edges is required before another press can fire.
// Ports:
//   clk     : system clock, rising edge
//   nreset2 : asynchronous active-low reset
//   jp      : joypad_irq_if.slave (p1x_c, stop_mode, int_ack in;
//             int_jp, wake, busy out -- all outputs registered)
module joypad_irq_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic         clk,
  input  logic         nreset2,
  joypad_irq_if.slave  jp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEBOUNCE = 2'd2,
    HELD     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DC_L   = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] ONE_L  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_L = CNT_W'(0);

  logic [SYNC_STAGES-1:0][3:0] sync_r;
  logic [SYNC_STAGES-1:0]      prime_r;
  state_t                      state_r, state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s, cnt_inc_s;
  logic                        any_low_s, primed_s, fire_s;
  logic                        int_jp_r, int_jp_s;
  logic                        wake_r, wake_s;
  logic                        busy_r, busy_s;

  // Pad synchroniser chain; reset to all-high (no key pressed).
  always_ff @(posedge clk or negedge nreset2) begin
    if (!nreset2) begin
      sync_r <= '1;
    end else begin
      sync_r[0] <= jp.p1x_c;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // The chain's reset value is a fake "all high". prime_r tracks when the last
  // stage holds a real pad sample, so a key held through reset never looks
  // like a release and cannot arm the sequencer.
  always_ff @(posedge clk or negedge nreset2) begin
    if (!nreset2) begin
      prime_r <= '0;
    end else begin
      prime_r <= {prime_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign any_low_s = ~(&sync_r[SYNC_STAGES-1]);
  assign primed_s  = &prime_r;
  assign cnt_inc_s = cnt_r + ONE_L;

  // Next-state, counter and firing decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    fire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (primed_s && !any_low_s) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (any_low_s) begin
          if (DEBOUNCE_CYC == 1) begin
            fire_s  = 1'b1;
            cnt_s   = ZERO_L;
            state_s = HELD;
          end else begin
            cnt_s   = ONE_L;
            state_s = DEBOUNCE;
          end
        end else begin
          state_s = ARMED;
        end
      end
      DEBOUNCE: begin
        if (!any_low_s) begin
          // Glitch shorter than the debounce window: discard it.
          cnt_s   = ZERO_L;
          state_s = ARMED;
        end else if (cnt_inc_s == DC_L) begin
          fire_s  = 1'b1;
          cnt_s   = ZERO_L;
          state_s = HELD;
        end else begin
          cnt_s   = cnt_inc_s;
        end
      end
      HELD: begin
        // Wait for DEBOUNCE_CYC consecutive all-high edges; presses here are ignored.
        if (any_low_s) begin
          cnt_s   = ZERO_L;
        end else if (cnt_inc_s == DC_L) begin
          cnt_s   = ZERO_L;
          state_s = ARMED;
        end else begin
          cnt_s   = cnt_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_L;
      end
    endcase
  end

  // Output decode; a firing edge wins over a coincident acknowledge.
  always_comb begin
    busy_s = (state_s == DEBOUNCE) || (state_s == HELD);
    wake_s = fire_s & jp.stop_mode;
    if (fire_s) begin
      int_jp_s = 1'b1;
    end else if (jp.int_ack) begin
      int_jp_s = 1'b0;
    end else begin
      int_jp_s = int_jp_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge nreset2) begin
    if (!nreset2) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_L;
      int_jp_r <= 1'b0;
      wake_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      int_jp_r <= int_jp_s;
      wake_r   <= wake_s;
      busy_r   <= busy_s;
    end
  end

  assign jp.int_jp = int_jp_r;
  assign jp.wake   = wake_r;
  assign jp.busy   = busy_r;

endmodule

// File: tb/tb_joypad_irq_ctrl.sv
// Testbench for joypad_irq_ctrl: a DEBOUNCE_CYC=4 instance driven by a
// per-edge vector table plus hand sequences, and a DEBOUNCE_CYC=1 instance
// for the STOP wake-up cases.
module tb_joypad_irq_ctrl;

  logic clk;
  logic nreset2;
  int   checks;
  int   errors;

  joypad_irq_if bus();
  joypad_irq_if bus1();

  joypad_irq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .nreset2(nreset2), .jp(bus)
  );

  joypad_irq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYC(1), .CNT_W(8)) dut1 (
    .clk(clk), .nreset2(nreset2), .jp(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] p;
    logic       stop;
    logic       ack;
    logic       e_int;
    logic       e_wake;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] p, input logic s, input logic a,
                     input logic ei, input logic ew, input logic eb);
    vec_t v;
    v.p = p; v.stop = s; v.ack = a; v.e_int = ei; v.e_wake = ew; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One main-DUT cycle: drive at negedge, sample 1ns after the rising edge.
  task automatic cyc(input logic [3:0] p, input logic s, input logic a);
    @(negedge clk);
    bus.p1x_c = p; bus.stop_mode = s; bus.int_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nreset2 = 1'b0;
    bus.p1x_c  = 4'hF; bus.stop_mode  = 1'b0; bus.int_ack  = 1'b0;
    bus1.p1x_c = 4'hF; bus1.stop_mode = 1'b0; bus1.int_ack = 1'b0;

    // Rows: p, stop, ack -> expected int_jp, wake, busy after that edge.
    // Pad sampled at edge n reaches the FSM at edge n+2.
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 0
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 1
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 2 first low sample (k)
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 3
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 4 DEBOUNCE cnt=1
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 5
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 6
    add(4'hE,1'b0,1'b0, 1'b1,1'b0,1'b1);  // 7 fire at k+5
    add(4'hE,1'b0,1'b0, 1'b1,1'b0,1'b1);  // 8
    add(4'hF,1'b0,1'b0, 1'b1,1'b0,1'b1);  // 9
    add(4'hF,1'b0,1'b1, 1'b0,1'b0,1'b1);  // 10 ack clears
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 11 HELD cnt=1
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 12
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 13
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 14 back to ARMED
    add(4'hB,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 15 two-edge glitch
    add(4'hB,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 16
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 17
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 18
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 19 glitch discarded
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 20
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 21
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 22
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 23
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 24
    add(4'hE,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 25
    add(4'hE,1'b0,1'b1, 1'b1,1'b0,1'b1);  // 26 fire with ack: set wins
    add(4'hD,1'b0,1'b0, 1'b1,1'b0,1'b1);  // 27 second key in HELD
    add(4'hD,1'b0,1'b1, 1'b0,1'b0,1'b1);  // 28 ack
    add(4'hD,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 29 no second interrupt
    add(4'hD,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 30
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 31
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 32
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 33
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 34
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b1);  // 35
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 36 ARMED again
    add(4'hF,1'b0,1'b0, 1'b0,1'b0,1'b0);  // 37
    add(4'h7,1'b1,1'b0, 1'b0,1'b0,1'b0);  // 38 new press in STOP
    add(4'h7,1'b1,1'b0, 1'b0,1'b0,1'b0);  // 39
    add(4'h7,1'b1,1'b0, 1'b0,1'b0,1'b1);  // 40
    add(4'h7,1'b1,1'b0, 1'b0,1'b0,1'b1);  // 41
    add(4'h7,1'b1,1'b0, 1'b0,1'b0,1'b1);  // 42
    add(4'h7,1'b1,1'b0, 1'b1,1'b1,1'b1);  // 43 fire + wake
    add(4'hF,1'b1,1'b1, 1'b0,1'b0,1'b1);  // 44 wake single cycle

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset int_jp", bus.int_jp, 1'b0);
    chk("reset wake",   bus.wake,   1'b0);
    chk("reset busy",   bus.busy,   1'b0);
    @(negedge clk);
    nreset2 = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].p, tbl[i].stop, tbl[i].ack);
      chk($sformatf("row%0d int_jp", i), bus.int_jp, tbl[i].e_int);
      chk($sformatf("row%0d wake", i),   bus.wake,   tbl[i].e_wake);
      chk($sformatf("row%0d busy", i),   bus.busy,   tbl[i].e_busy);
    end

    // Key held through reset never fires
    @(negedge clk);
    nreset2 = 1'b0;
    bus.p1x_c = 4'h7; bus.stop_mode = 1'b0; bus.int_ack = 1'b0;
    repeat (2) @(negedge clk);
    nreset2 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(4'h7, 1'b0, 1'b0);
      chk($sformatf("held%0d int_jp", i), bus.int_jp, 1'b0);
      chk($sformatf("held%0d busy", i),   bus.busy,   1'b0);
    end
    for (int i = 0; i < 5; i++) cyc(4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'h7, 1'b0, 1'b0);
    chk("post-idle k+4 int_jp", bus.int_jp, 1'b0);
    cyc(4'h7, 1'b0, 1'b0);
    chk("post-idle k+5 int_jp", bus.int_jp, 1'b1);

    // Release to ARMED with int_jp still set, then reset mid-DEBOUNCE
    for (int i = 0; i < 10; i++) cyc(4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'hE, 1'b0, 1'b0);
    chk("mid-debounce busy", bus.busy, 1'b1);
    chk("mid-debounce int_jp", bus.int_jp, 1'b1);
    #1;
    nreset2 = 1'b0;
    #1;
    chk("async reset int_jp", bus.int_jp, 1'b0);
    chk("async reset busy",   bus.busy,   1'b0);
    chk("async reset wake",   bus.wake,   1'b0);
    @(negedge clk);
    nreset2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(4'hE, 1'b0, 1'b0);
      chk($sformatf("post-reset%0d int_jp", i), bus.int_jp, 1'b0);
      chk($sformatf("post-reset%0d busy", i),   bus.busy,   1'b0);
    end
    for (int i = 0; i < 5; i++) cyc(4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(4'hE, 1'b0, 1'b0);
    chk("repress k+4 int_jp", bus.int_jp, 1'b0);
    cyc(4'hE, 1'b0, 1'b0);
    chk("repress k+5 int_jp", bus.int_jp, 1'b1);

    // DEBOUNCE_CYC=1: wake in STOP, single cycle, coincident with int_jp
    @(negedge clk);
    bus1.stop_mode = 1'b1; bus1.p1x_c = 4'hD;
    @(posedge clk); #1;
    chk("dc1 e0 wake", bus1.wake, 1'b0);
    chk("dc1 e0 int_jp", bus1.int_jp, 1'b0);
    @(posedge clk); #1;
    chk("dc1 e1 wake", bus1.wake, 1'b0);
    chk("dc1 e1 int_jp", bus1.int_jp, 1'b0);
    @(posedge clk); #1;
    chk("dc1 fire wake", bus1.wake, 1'b1);
    chk("dc1 fire int_jp", bus1.int_jp, 1'b1);
    chk("dc1 fire busy", bus1.busy, 1'b1);
    @(posedge clk); #1;
    chk("dc1 after wake", bus1.wake, 1'b0);
    chk("dc1 after int_jp", bus1.int_jp, 1'b1);
    @(negedge clk);
    bus1.p1x_c = 4'hF; bus1.int_ack = 1'b1;
    @(posedge clk); #1;
    chk("dc1 ack int_jp", bus1.int_jp, 1'b0);
    @(negedge clk);
    bus1.int_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dc1 released busy", bus1.busy, 1'b0);
    @(negedge clk);
    bus1.stop_mode = 1'b0; bus1.p1x_c = 4'hD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("dc1 nostop e1 int_jp", bus1.int_jp, 1'b0);
    @(posedge clk); #1;
    chk("dc1 nostop int_jp", bus1.int_jp, 1'b1);
    chk("dc1 nostop wake", bus1.wake, 1'b0);
    @(posedge clk); #1;
    chk("dc1 nostop next wake", bus1.wake, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
